// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD seven-segment display path.
// Segment encoding is active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam seg_t SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam seg_t       SEG_DASH = 7'h3F;
  localparam seg_t       SEG_OFF  = 7'h7F;
  localparam logic [3:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_DASH;
    if (i_bcd <= BCD_MAX) begin
      case (i_bcd)
        4'd0:    o_seg_c = SEG_DIGIT[0];
        4'd1:    o_seg_c = SEG_DIGIT[1];
        4'd2:    o_seg_c = SEG_DIGIT[2];
        4'd3:    o_seg_c = SEG_DIGIT[3];
        4'd4:    o_seg_c = SEG_DIGIT[4];
        4'd5:    o_seg_c = SEG_DIGIT[5];
        4'd6:    o_seg_c = SEG_DIGIT[6];
        4'd7:    o_seg_c = SEG_DIGIT[7];
        4'd8:    o_seg_c = SEG_DIGIT[8];
        4'd9:    o_seg_c = SEG_DIGIT[9];
        default: o_seg_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed scanner driving NUM_DIGITS BCD digits onto one active-low 7-seg bus.
// Optional brightness PWM via `define BCD_SEG_SCANNER_PWM_EN (adds BRIGHT input).
module bcd_seg_scanner
  import bcd_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP_IN,
  input  logic                    BLANK_LZ,
`ifdef BCD_SEG_SCANNER_PWM_EN
  input  logic [2:0]              BRIGHT,
`endif
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    SCAN_TICK
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  scan_state_e           r_state;
  scan_state_e           w_state_nxt;
  logic                  w_load;
  logic                  w_scan;

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [DIG_W-1:0]      r_snap_dig;
  logic [NUM_DIGITS-1:0] r_snap_dp;
  logic                  r_snap_blz;

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_tick;

  logic                  w_term;
  logic                  w_wrap;
  logic                  w_on;
  logic                  w_run;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [NUM_DIGITS-1:0] w_an;
  logic [3:0]            w_digit;
  logic                  w_dp_sel;
  logic                  w_blank_sel;
  logic [6:0]            w_seg_c;

  // First edge after reset only loads the snapshot; scanning starts on the next one
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= ST_LOAD;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_scan      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SCAN;
      end
      ST_SCAN: w_scan = 1'b1;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign w_term = w_scan && (r_presc == PRE_W'(REFRESH_DIV - 1));
  assign w_wrap = w_term && (r_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_term) begin
      r_presc <= '0;
      r_idx   <= w_wrap ? '0 : r_idx + IDX_W'(1);
    end else if (w_scan) begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

`ifdef BCD_SEG_SCANNER_PWM_EN
  logic [2:0]  r_bright;
  logic [31:0] w_thr;
`endif

  // Frame snapshot: inputs only take effect at a frame boundary, so a frame never tears
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_snap_dig <= '0;
      r_snap_dp  <= '0;
      r_snap_blz <= 1'b0;
`ifdef BCD_SEG_SCANNER_PWM_EN
      r_bright   <= '0;
`endif
    end else if (w_load || w_wrap) begin
      r_snap_dig <= DIGITS;
      r_snap_dp  <= DP_IN;
      r_snap_blz <= BLANK_LZ;
`ifdef BCD_SEG_SCANNER_PWM_EN
      r_bright   <= BRIGHT;
`endif
    end
  end

  // A digit is blank while it and every more-significant digit are zero
  always_comb begin
    w_run   = r_snap_blz;
    w_blank = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      w_run      = w_run & (r_snap_dig[4*i +: 4] == 4'd0);
      w_blank[i] = w_run;
    end
  end

  always_comb begin
    w_digit     = '0;
    w_an        = '1;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit     = r_snap_dig[4*i +: 4];
        w_an[i]     = 1'b0;
        w_dp_sel    = r_snap_dp[i];
        w_blank_sel = w_blank[i];
      end
    end
  end

  bcd_to_seg u_dec (
    .i_bcd   (w_digit),
    .o_seg_c (w_seg_c)
  );

`ifdef BCD_SEG_SCANNER_PWM_EN
  assign w_thr = ((32'(r_bright) + 32'd1) * 32'(REFRESH_DIV)) / 32'd8;
  assign w_on  = (32'(r_presc) < w_thr);
`else
  assign w_on  = 1'b1;
`endif

  // Dimmed portion of a slot turns the whole digit off, decimal point included
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_seg  <= SEG_OFF;
      r_dp   <= 1'b1;
      r_an   <= '1;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_term;
      if (w_scan) begin
        if (w_on) begin
          r_an  <= w_an;
          r_seg <= w_blank_sel ? SEG_OFF : w_seg_c;
          r_dp  <= ~w_dp_sel;
        end else begin
          r_an  <= '1;
          r_seg <= SEG_OFF;
          r_dp  <= 1'b1;
        end
      end
    end
  end

  assign SEG       = r_seg;
  assign DP        = r_dp;
  assign AN        = r_an;
  assign SCAN_TICK = r_tick;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed scoreboard bench for bcd_seg_scanner (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_bcd_seg_scanner;

  logic        CLK;
  logic        CLR;
  logic [15:0] DIGITS;
  logic [3:0]  DP_IN;
  logic        BLANK_LZ;
  logic [2:0]  BRIGHT;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  logic        SCAN_TICK;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   thr    = 4;

  bcd_seg_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .DIGITS    (DIGITS),
    .DP_IN     (DP_IN),
    .BLANK_LZ  (BLANK_LZ),
`ifdef BCD_SEG_SCANNER_PWM_EN
    .BRIGHT    (BRIGHT),
`endif
    .SEG       (SEG),
    .DP        (DP),
    .AN        (AN),
    .SCAN_TICK (SCAN_TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  // Expected frame from the current inputs: blank digits above the highest nonzero one
  task automatic push_frame();
    int   hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < 4; i++) if (DIGITS[4*i +: 4] != 4'd0) hi = i;
    for (int s = 0; s < 4; s++) begin
      e.an    = 4'hF;
      e.an[s] = 1'b0;
      e.seg   = (BLANK_LZ && s > hi && s != 0) ? 7'h7F : ref_seg(DIGITS[4*s +: 4]);
      e.dp    = ~DP_IN[s];
      sb_q.push_back(e);
    end
  endtask

  task automatic sync_frame();
    logic [3:0] prev;
    prev = AN;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (AN == 4'b1110 && prev != 4'b1110) return;
      prev = AN;
    end
    checks++;
    errors++;
    $error("FAIL sync_timeout: observed no frame start, expected AN=1110 within 64 cycles");
  endtask

  task automatic check_frame(input int change_slot, input logic [15:0] new_dig);
    exp_t e;
    logic on;
    for (int s = 0; s < 4; s++) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty: observed empty queue, expected entry for slot %0d", s);
        return;
      end
      e = sb_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (s == change_slot && c == 0) DIGITS = new_dig;
        on = (c < thr);
        chk($sformatf("an_s%0d_c%0d", s, c),   8'(AN),  on ? 8'(e.an)  : 8'h0F);
        chk($sformatf("seg_s%0d_c%0d", s, c),  8'(SEG), on ? 8'(e.seg) : 8'h7F);
        chk($sformatf("dp_s%0d_c%0d", s, c),   8'(DP),  on ? 8'(e.dp)  : 8'h01);
        chk($sformatf("tick_s%0d_c%0d", s, c), 8'(SCAN_TICK), (c == 3) ? 8'h01 : 8'h00);
        if (!(s == 3 && c == 3)) @(negedge CLK);
      end
    end
  endtask

  // Called at the negedge where CLR rises
  task automatic post_reset_check();
    logic [6:0] s0;
    s0 = ref_seg(DIGITS[3:0]);
    @(negedge CLK);
    chk("rst_edge1_an",  8'(AN),  8'h0F);
    chk("rst_edge1_seg", 8'(SEG), 8'h7F);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("rst_slot0_an_c%0d", c),   8'(AN),  8'h0E);
      chk($sformatf("rst_slot0_seg_c%0d", c),  8'(SEG), 8'(s0));
      chk($sformatf("rst_slot0_tick_c%0d", c), 8'(SCAN_TICK), (c == 3) ? 8'h01 : 8'h00);
    end
    @(negedge CLK);
    chk("rst_slot1_an", 8'(AN), 8'h0D);
  endtask

  task automatic apply(input logic [15:0] dig, input logic [3:0] dp, input logic blz);
    DIGITS   = dig;
    DP_IN    = dp;
    BLANK_LZ = blz;
    push_frame();
    repeat (2) sync_frame();
    check_frame(-1, 16'h0);
  endtask

  initial begin
    CLR      = 1'b1;
    DIGITS   = 16'h1234;
    DP_IN    = 4'h0;
    BLANK_LZ = 1'b0;
    BRIGHT   = 3'd7;
    #1 CLR   = 1'b0;

    repeat (2) @(negedge CLK);
    chk("reset_an",   8'(AN),  8'h0F);
    chk("reset_seg",  8'(SEG), 8'h7F);
    chk("reset_dp",   8'(DP),  8'h01);
    chk("reset_tick", 8'(SCAN_TICK), 8'h00);
    CLR = 1'b1;
    post_reset_check();

    push_frame();
    sync_frame();
    check_frame(-1, 16'h0);

    apply(16'h1234, 4'b0101, 1'b0);
    apply(16'h0070, 4'b0000, 1'b1);
    apply(16'h0000, 4'b0000, 1'b1);
    apply(16'h00A5, 4'b1000, 1'b1);
    apply(16'h0070, 4'b0000, 1'b0);

    // Mid-frame input change must not reach the display until the next frame
    DIGITS = 16'h1111;
    push_frame();
    repeat (2) sync_frame();
    check_frame(1, 16'h2222);
    push_frame();
    sync_frame();
    check_frame(-1, 16'h0);

    // Asynchronous reset in the middle of a slot
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #2 CLR = 1'b0;
    #1;
    chk("midrst_an",   8'(AN),  8'h0F);
    chk("midrst_seg",  8'(SEG), 8'h7F);
    chk("midrst_dp",   8'(DP),  8'h01);
    chk("midrst_tick", 8'(SCAN_TICK), 8'h00);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("midrst_hold_an", 8'(AN), 8'h0F);
    CLR = 1'b1;
    post_reset_check();

`ifdef BCD_SEG_SCANNER_PWM_EN
    BRIGHT = 3'd3;
    thr    = 2;
    apply(16'h1234, 4'b0001, 1'b0);
    BRIGHT = 3'd7;
    thr    = 4;
    apply(16'h1234, 4'b0001, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
